// File: rtl/piece_controller.sv
// piece_controller: owns the falling piece. Turns spawn/move/drop requests
// into candidate bitmaps for the move validator, then commits or rejects
// each one. A landed piece goes to the merge stage with a one-cycle lock pulse.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no piece; waiting for a spawn with a nonzero shape
//   ACTIVE | piece present; takes one move/drop request per cycle
//   CHECK  | next_location is shown to the validator; verdict sampled
//   LOCK   | landed piece held on piece_location with lock high
//   OVER   | spawn was rejected; everything ignored until reset
module piece_controller #(
    parameter  int PLAY_WIDTH  = 10,
    parameter  int PLAY_HEIGHT = 15,
    localparam int N           = PLAY_WIDTH * PLAY_HEIGHT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         spawn,
    input  logic [N-1:0] spawn_shape,
    input  logic         move_left,
    input  logic         move_right,
    input  logic         move_down,
    input  logic         drop,
    input  logic         not_valid,
    output logic [N-1:0] next_location,
    output logic [N-1:0] piece_location,
    output logic         busy,
    output logic         lock,
    output logic         game_over
);

    typedef enum logic [2:0] {IDLE, ACTIVE, CHECK, LOCK, OVER} state_t;
    typedef enum logic [1:0] {K_SPAWN, K_DOWN, K_SIDE, K_DROP} kind_t;

    // One bit per row in the first/last column, and the whole bottom row.
    localparam logic [N-1:0] COL_FIRST = {PLAY_HEIGHT{{(PLAY_WIDTH-1){1'b0}}, 1'b1}};
    localparam logic [N-1:0] COL_LAST  = {PLAY_HEIGHT{1'b1, {(PLAY_WIDTH-1){1'b0}}}};
    localparam logic [N-1:0] ROW_LAST  = {{PLAY_WIDTH{1'b1}}, {(N-PLAY_WIDTH){1'b0}}};

    state_t state;
    kind_t  kind;
    logic   force_reject;

    logic [N-1:0] cand_left, cand_right, cand_down, next_down;
    logic         at_left, at_right, at_bottom, next_at_bottom, accepted;

    // Candidate bitmaps and wall checks for the committed piece; the drop
    // loop uses the same checks on the candidate it is about to commit.
    always_comb begin
        cand_left      = piece_location >> 1;
        cand_right     = piece_location << 1;
        cand_down      = piece_location << PLAY_WIDTH;
        next_down      = next_location << PLAY_WIDTH;
        at_left        = |(piece_location & COL_FIRST);
        at_right       = |(piece_location & COL_LAST);
        at_bottom      = |(piece_location & ROW_LAST);
        next_at_bottom = |(next_location & ROW_LAST);
        accepted       = !not_valid && !force_reject;
    end

    // Main sequencer: all outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            kind           <= K_SPAWN;
            force_reject   <= 1'b0;
            next_location  <= '0;
            piece_location <= '0;
            busy           <= 1'b0;
            lock           <= 1'b0;
            game_over      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (spawn && (|spawn_shape)) begin
                        next_location <= spawn_shape;
                        kind          <= K_SPAWN;
                        force_reject  <= 1'b0;
                        busy          <= 1'b1;
                        state         <= CHECK;
                    end
                end
                ACTIVE: begin
                    if (drop || move_down) begin
                        next_location <= cand_down;
                        force_reject  <= at_bottom;
                        kind          <= drop ? K_DROP : K_DOWN;
                        busy          <= 1'b1;
                        state         <= CHECK;
                    end else if (move_left) begin
                        next_location <= cand_left;
                        force_reject  <= at_left;
                        kind          <= K_SIDE;
                        busy          <= 1'b1;
                        state         <= CHECK;
                    end else if (move_right) begin
                        next_location <= cand_right;
                        force_reject  <= at_right;
                        kind          <= K_SIDE;
                        busy          <= 1'b1;
                        state         <= CHECK;
                    end
                end
                CHECK: begin
                    if (accepted) begin
                        piece_location <= next_location;
                        if (kind == K_DROP) begin
                            // Keep falling: the committed candidate is the new base.
                            next_location <= next_down;
                            force_reject  <= next_at_bottom;
                        end else begin
                            busy  <= 1'b0;
                            state <= ACTIVE;
                        end
                    end else begin
                        case (kind)
                            K_SPAWN: begin
                                next_location <= '0;
                                game_over     <= 1'b1;
                                busy          <= 1'b0;
                                state         <= OVER;
                            end
                            K_SIDE: begin
                                next_location <= piece_location;
                                busy          <= 1'b0;
                                state         <= ACTIVE;
                            end
                            default: begin
                                lock  <= 1'b1;
                                state <= LOCK;
                            end
                        endcase
                    end
                end
                LOCK: begin
                    lock           <= 1'b0;
                    busy           <= 1'b0;
                    piece_location <= '0;
                    next_location  <= '0;
                    state          <= IDLE;
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller. A background bitmap stands in for the
// move validator: not_valid is high whenever the candidate overlaps it.
module tb_piece_controller;

    localparam int W = 10;
    localparam int H = 15;
    localparam int N = W * H;

    logic         clk;
    logic         reset;
    logic         spawn;
    logic [N-1:0] spawn_shape;
    logic         move_left, move_right, move_down, drop;
    logic         not_valid;
    logic [N-1:0] next_location, piece_location;
    logic         busy, lock, game_over;
    logic [N-1:0] bg;

    int n_cmp;
    int n_bad;

    localparam logic [N-1:0] P0 = 150'hF;

    piece_controller #(.PLAY_WIDTH(W), .PLAY_HEIGHT(H)) dut (
        .clk            (clk),
        .reset          (reset),
        .spawn          (spawn),
        .spawn_shape    (spawn_shape),
        .move_left      (move_left),
        .move_right     (move_right),
        .move_down      (move_down),
        .drop           (drop),
        .not_valid      (not_valid),
        .next_location  (next_location),
        .piece_location (piece_location),
        .busy           (busy),
        .lock           (lock),
        .game_over      (game_over)
    );

    assign not_valid = |(next_location & bg);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        spawn      = 1'b0;
        move_left  = 1'b0;
        move_right = 1'b0;
        move_down  = 1'b0;
        drop       = 1'b0;
    endtask

    task automatic do_spawn(input logic [N-1:0] shape);
        spawn_shape = shape;
        spawn       = 1'b1;
        tick();
        clear_req();
    endtask

    int busy_cnt;
    int lock_cnt;
    int guard;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        bg = '0;
        spawn_shape = '0;
        clear_req();
        reset = 1'b0;
        #3;
        chk("rst_next", next_location, '0);
        chk("rst_piece", piece_location, '0);
        chk("rst_busy", {149'b0, busy}, '0);
        chk("rst_lock", {149'b0, lock}, '0);
        chk("rst_over", {149'b0, game_over}, '0);
        #9 reset = 1'b1;

        // 1: spawn, rejected left, accepted right, request during busy dropped
        do_spawn(P0);
        chk("spawn_busy", {149'b0, busy}, 150'd1);
        chk("spawn_next", next_location, P0);
        tick();
        chk("spawn_piece", piece_location, P0);
        chk("spawn_busy_off", {149'b0, busy}, '0);
        chk("spawn_over", {149'b0, game_over}, '0);
        move_left = 1'b1; tick(); clear_req();
        chk("left_busy", {149'b0, busy}, 150'd1);
        tick();
        chk("left_busy_off", {149'b0, busy}, '0);
        chk("left_piece", piece_location, P0);
        chk("left_next", next_location, P0);
        move_right = 1'b1; tick(); clear_req();
        move_left = 1'b1; tick(); clear_req();
        chk("right_piece", piece_location, P0 << 1);
        tick();
        chk("busy_drop_req", {149'b0, busy}, '0);
        chk("busy_drop_piece", piece_location, P0 << 1);

        // 2: back to bits 3:0, then down with a lower-priority right alongside
        move_left = 1'b1; tick(); clear_req(); tick();
        chk("left_ok", piece_location, P0);
        move_down = 1'b1; move_right = 1'b1; tick(); clear_req(); tick();
        chk("down_piece", piece_location, P0 << W);
        chk("down_nolock", {149'b0, lock}, '0);

        // 3: overlap lock against a full bottom row
        bg = '0;
        bg[149:140] = '1;
        for (int i = 0; i < 12; i++) begin
            move_down = 1'b1; tick(); clear_req(); tick();
        end
        chk("row13_piece", piece_location, P0 << 130);
        move_down = 1'b1; tick(); clear_req();
        chk("ovl_check_lock", {149'b0, lock}, '0);
        tick();
        chk("ovl_lock", {149'b0, lock}, 150'd1);
        chk("ovl_lock_piece", piece_location, P0 << 130);
        chk("ovl_lock_busy", {149'b0, busy}, 150'd1);
        tick();
        chk("ovl_lock_fall", {149'b0, lock}, '0);
        chk("ovl_idle_piece", piece_location, '0);
        chk("ovl_idle_next", next_location, '0);
        chk("ovl_idle_busy", {149'b0, busy}, '0);

        // 4: hard drop on an empty field
        bg = '0;
        do_spawn(P0); tick();
        drop = 1'b1; tick(); clear_req();
        busy_cnt = 0;
        lock_cnt = 0;
        guard = 0;
        while (busy && guard < 40) begin
            busy_cnt++;
            if (lock) begin
                lock_cnt++;
                chk("drop_lock_piece", piece_location, P0 << 140);
            end
            tick();
            guard++;
        end
        chk("drop_busy_cycles", 150'(busy_cnt), 150'd16);
        chk("drop_lock_cycles", 150'(lock_cnt), 150'd1);
        chk("drop_idle_piece", piece_location, '0);

        // 5: spawn rejected, later spawns ignored
        bg = '0;
        bg[2] = 1'b1;
        do_spawn(P0); tick();
        chk("rej_over", {149'b0, game_over}, 150'd1);
        chk("rej_piece", piece_location, '0);
        bg = '0;
        do_spawn(P0); tick();
        chk("over_sticky", {149'b0, game_over}, 150'd1);
        chk("over_piece", piece_location, '0);
        chk("over_busy", {149'b0, busy}, '0);

        // 6: reset in the middle of a drop
        reset = 1'b0;
        #7 reset = 1'b1;
        chk("rst2_over", {149'b0, game_over}, '0);
        do_spawn(P0); tick();
        drop = 1'b1; tick(); clear_req();
        for (int i = 0; i < 4; i++) tick();
        chk("mid_drop_piece", piece_location, P0 << 40);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_piece", piece_location, '0);
        chk("mid_rst_next", next_location, '0);
        chk("mid_rst_busy", {149'b0, busy}, '0);
        chk("mid_rst_lock", {149'b0, lock}, '0);
        tick();
        tick();
        chk("mid_rst_nolock", {149'b0, lock}, '0);
        #3 reset = 1'b1;
        do_spawn(P0 << 3); tick();
        chk("post_rst_piece", piece_location, P0 << 3);
        chk("post_rst_over", {149'b0, game_over}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
